// File: rtl/fetch_queue_unit.sv
// Fetch stage: issues sequential reads to a 1-cycle instruction memory and queues {instr, pc} for decode.
// Head visible 2 cycles after issue; requests stop when the queue could overflow; redirect flushes all.
module fetch_queue_unit #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic [PC_W-1:0]            redirect_offset,
  input  logic                       redirect_sign,
  input  logic                       halt_req,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] LIMIT    = (CW+1)'(DEPTH);
  localparam logic [CW:0] LIMIT_M1 = (CW+1)'(DEPTH-1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            halted_q, halted_d;

  logic            pop;
  logic            push;
  logic [CW:0]     level;

  // Queued entries plus the read in flight: every one needs a slot.
  always_comb begin
    level     = {1'b0, count_q} + (CW+1)'(inflight_q);
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    push      = inflight_q && !redirect_valid && !reset;
    imem_req  = !reset && !halted_q && !redirect_valid && (level < LIMIT) &&
                !((level == LIMIT_M1) && inflight_q && !pop);
    imem_addr = fetch_pc_q;
    out_instr = mem_q[rd_ptr_q].instr;
    out_pc    = mem_q[rd_ptr_q].pc;
    halted    = halted_q;
    occupancy = count_q;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    halted_d      = halted_q | halt_req;
    if (redirect_valid) begin
      fetch_pc_d = redirect_sign ? redirect_pc + redirect_offset
                                 : redirect_pc - redirect_offset;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = imem_req;
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + PC_W'(1);
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: imem_data, pc: inflight_pc_q};
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed cycle table, hand sequences and random stimulus vs a queue model.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [8:0]  imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] redirect_offset;
  logic        redirect_sign;
  logic        halt_req;
  logic        halted;
  logic [2:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_queue_unit #(.PC_W(16), .INSTR_W(9), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_offset(redirect_offset), .redirect_sign(redirect_sign),
    .halt_req(halt_req), .halted(halted), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom(input logic [15:0] a);
    return a[8:0];
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) imem_data <= rom(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch pointer, one pending read, and a queue of fetched PCs.
  logic [15:0] m_pc;
  logic        m_inf;
  logic [15:0] m_inf_pc;
  logic [15:0] m_q[$];
  logic        m_halted;
  logic        e_req, e_valid, e_pop;

  task automatic model_expect();
    int lvl;
    lvl     = m_q.size() + int'(m_inf);
    e_valid = (m_q.size() != 0);
    e_pop   = e_valid && out_ready;
    e_req   = !reset && !m_halted && !redirect_valid && (lvl < 4) &&
              !(lvl == 3 && m_inf && !e_pop);
    chk("m_req", imem_req, e_req);
    chk("m_valid", out_valid, e_valid);
    chk("m_occ", occupancy, m_q.size());
    chk("m_halted", halted, m_halted);
    if (!reset) chk("m_addr", imem_addr, m_pc);
    if (e_valid) begin
      chk("m_pc", out_pc, m_q[0]);
      chk("m_instr", out_instr, rom(m_q[0]));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = 16'd0; m_inf = 1'b0; m_inf_pc = 16'd0; m_halted = 1'b0;
      m_q.delete();
    end else begin
      if (redirect_valid) begin
        m_pc  = redirect_sign ? redirect_pc + redirect_offset : redirect_pc - redirect_offset;
        m_inf = 1'b0;
        m_q.delete();
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_inf_pc);
        if (e_req) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 16'd1;
        end
        m_inf = e_req;
      end
      if (halt_req) m_halted = 1'b1;
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rv,
                       input logic [15:0] rpc, input logic [15:0] roff,
                       input logic rs, input logic hr);
    reset = rst; out_ready = rdy; redirect_valid = rv;
    redirect_pc = rpc; redirect_offset = roff; redirect_sign = rs; halt_req = hr;
    @(negedge clk);
    model_expect();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rdy; logic rv; logic [15:0] rpc; logic [15:0] roff; logic rs; logic hr;
    logic e_req; logic [15:0] e_addr; logic e_valid; logic [15:0] e_pc;
    logic [2:0] e_occ; logic e_halted;
  } vec_t;

  vec_t vec [16];

  initial begin
    int got;
    vec[0]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 3'd0, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 3'd1, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0001, 3'd1, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 16'h2, 16'h5, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002, 3'd1, 1'b0};
    vec[5]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 16'h0000, 3'd0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 3'd0, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFD, 3'd1, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'hFFFE, 3'd1, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 3'd1, 1'b0};
    vec[10] = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 3'd1, 1'b0};
    vec[11] = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001, 3'd1, 1'b0};
    vec[12] = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0002, 3'd1, 1'b1};
    vec[13] = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0003, 3'd1, 1'b1};
    vec[14] = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 16'h0000, 3'd0, 1'b1};
    vec[15] = '{1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 16'h0000, 3'd0, 1'b1};

    // Bring state out of X before the model starts tracking.
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    redirect_offset = '0; redirect_sign = 1'b0; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_update();

    drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_halted", halted, 1'b0);
    tick();

    // Streaming, redirect with wrap below zero, then halt and drain.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, vec[i].rdy, vec[i].rv, vec[i].rpc, vec[i].roff, vec[i].rs, vec[i].hr);
      chk($sformatf("tbl%0d_req", i), imem_req, vec[i].e_req);
      chk($sformatf("tbl%0d_addr", i), imem_addr, vec[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), out_valid, vec[i].e_valid);
      chk($sformatf("tbl%0d_occ", i), occupancy, vec[i].e_occ);
      chk($sformatf("tbl%0d_halted", i), halted, vec[i].e_halted);
      if (vec[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, vec[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), out_instr, rom(vec[i].e_pc));
      end
      tick();
    end

    // Backpressure: queue saturates, then drains in order without gaps or repeats.
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("full_occ", occupancy, 3'd4);
    chk("full_req", imem_req, 1'b0);
    tick();
    got = 0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      if (out_valid === 1'b1 && got < 8) begin
        chk("drain_pc", out_pc, got);
        got++;
      end
      tick();
    end
    chk("drain_count", got, 8);

    // Reset with a nearly full queue and a read in flight; simultaneous halt is overridden.
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("pre_rst_occ", occupancy, 3'd3);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("post_rst_occ", occupancy, 3'd0);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_halted", halted, 1'b0);
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 16'h0000);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            16'($urandom), 16'($urandom_range(0, 40)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
